oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Shares the single external memory bus between the CPU core (decoder/sequencer datapath) and an OAM DMA engine.
- A CPU write to the DMA register starts a 160-byte copy from {src,8'h00} to OAM, one byte per M-cycle step.
- While DMA owns the bus, CPU accesses outside HRAM are blocked; HRAM and the DMA register stay reachable.

Parameters:
- DMA_LEN, 160, bytes copied per transfer (index width 8)
- DMA_REG_ADDR, 16'hFF46, DMA source/start register
- HRAM_LO, 16'hFF80, first HRAM address
- HRAM_HI, 16'hFFFE, last HRAM address

Ports:
- clk  in  1  step clock; one bus op per cycle
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU address bus (s_ab result)
- cpu_wr  in  1  CPU write strobe (t_db = MEM)
- cpu_rd  in  1  CPU read strobe (s_db = MEM)
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  data returned to CPU db
- mem_addr  out  16  external bus address
- mem_rd  out  1  external read strobe
- mem_wr  out  1  external write strobe
- mem_wdata  out  8  external write data
- mem_rdata  in  8  external read data, valid same cycle as mem_rd
- hram_addr  out  7  HRAM offset (cpu_addr - HRAM_LO)
- hram_wr  out  1  HRAM write strobe
- hram_wdata  out  8  HRAM write data
- hram_rdata  in  8  HRAM read data, same cycle
- oam_wr  out  1  OAM write strobe
- oam_idx  out  8  OAM byte index 0..159
- oam_wdata  out  8  OAM write data
- dma_active  out  1  OAM/bus locked to DMA

Behaviour:
- Reset (async, rst_n low): state IDLE, dma_src = 8'h00, idx = 0, restart flag = 0. All strobes 0, dma_active 0, mem_addr/oam_idx/oam_wdata 0. cpu_rdata = 8'hFF.
- States:
  - IDLE: no transfer.
  - START: one-cycle setup delay.
  - ACTIVE: one source read per cycle.
  - DRAIN: final OAM write.
- IDLE -> START on cpu_wr to DMA_REG_ADDR. dma_src latches cpu_wdata; idx <- 0.
- START -> ACTIVE unconditionally next cycle.
- ACTIVE, each cycle:
  - mem_rd = 1, mem_addr = {src_eff, idx}, where src_eff = dma_src with bit5 cleared when dma_src >= 8'hE0.
  - Data is registered, and idx increments.
  - When idx == DMA_LEN-1 the state goes to DRAIN.
- OAM write pipeline: oam_wr pulses the cycle after each ACTIVE read, with oam_idx = that read's idx and oam_wdata = the registered mem_rdata. Exactly 160 oam_wr pulses per uninterrupted transfer, idx 0..159 in order.
- DRAIN: last oam_wr, then IDLE. Total latency from the register-write cycle to the last oam_wr = 162 cycles.
- dma_active:
  - 1 in ACTIVE and DRAIN.
  - 1 in START only when restart flag = 1.
  - 0 in IDLE.
- CPU routing:
  - Address in [HRAM_LO, HRAM_HI]: always to the hram_* port, any state. cpu_rdata = hram_rdata.
  - Address == DMA_REG_ADDR: reads return dma_src in any state. Writes latch dma_src and start/restart.
  - Other addresses, dma_active = 0: passthrough to mem_* (mem_rd = cpu_rd, mem_wr = cpu_wr), cpu_rdata = mem_rdata.
  - Other addresses, dma_active = 1: reads return 8'hFF, writes dropped, no mem strobe.
- Restart: a DMA_REG_ADDR write in ACTIVE or DRAIN does the following.
  - The pending OAM write for the in-flight byte still completes next cycle.
  - State -> START with restart flag = 1, and idx <- 0.
  - The new dma_src is used from the next ACTIVE.
- Restart flag clears on entry to IDLE.
- Write to DMA_REG_ADDR in START: re-latch dma_src, remain one more cycle in START (delay restarts).
- Simultaneous cpu_rd and cpu_wr: write wins, no read strobe issued.
- mem_* strobes are never driven by CPU and DMA in the same cycle; DMA has priority whenever the state is ACTIVE.
- Reset mid-transfer: immediate IDLE, no further oam_wr.

Decomposition:
- Shared package (cpu_pkg alongside reg8_t/reg16_t):
  - dma_state_t {DMA_IDLE, DMA_START, DMA_ACTIVE, DMA_DRAIN}.
  - Address constants: DMA_REG_ADDR, HRAM_LO, HRAM_HI, OAM_BASE.
- One sub-module: bus_region_decoder. Combinational; cpu_addr -> {is_hram, is_dma_reg, is_other}.
- FSM, counter and routing mux stay in the top block.

Test Plan:
- Write 8'hC1 to FF46 from IDLE -> START at t+1, reads C100..C19F at t+2..t+161, oam_wr idx 0..159 at t+3..t+162 with matching data, dma_active 0 at t+1, 1 at t+2..t+162, 0 at t+163.
- During DMA, CPU read of C000 -> cpu_rdata FF, no mem strobe; CPU write/read FF90 = 8'h5A -> hram_wr at offset 8'h10, readback 5A.
- Write 8'hFE to FF46 -> source reads at DE00..DE9F (bit5 cleared); read FF46 returns FE.
- Restart: write 8'hC2 at ACTIVE idx 50 -> oam_wr idx 50 still issued; START with dma_active held 1; next reads C200 upward; 160 further oam_wr, idx 0..159.
- rst_n low at ACTIVE idx 80 (async, mid-cycle) -> outputs zero immediately, state IDLE, no oam_wr after; a subsequent FF46 write starts cleanly at idx 0.
- IDLE passthrough: CPU write 8'h33 to 8000 -> mem_wr = 1, mem_addr 8000, mem_wdata 33; read returns mem_rdata; dma_active stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU core types and memory-map constants.
// Used by the bus arbiter and its region decoder.
package cpu_pkg;

  typedef logic [7:0]  reg8_t;
  typedef logic [15:0] reg16_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_ACTIVE,
    DMA_DRAIN
  } dma_state_t;

  localparam int unsigned DMA_LEN = 160;
  localparam reg8_t DMA_LAST = 8'(DMA_LEN - 1);

  localparam reg16_t DMA_REG_ADDR = 16'hFF46;
  localparam reg16_t HRAM_LO      = 16'hFF80;
  localparam reg16_t HRAM_HI      = 16'hFFFE;
  localparam reg16_t OAM_BASE     = 16'hFE00;

  // Sources at E0..FF alias down into work RAM
  function automatic reg8_t src_eff(input reg8_t s);
    return (s >= 8'hE0) ? (s & 8'hDF) : s;
  endfunction

endpackage

// File: rtl/bus_region_decoder.sv
// Classifies a CPU address as HRAM, DMA register or other.
// Purely combinational; exactly one output is high.
module bus_region_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] cpu_addr,
  output logic        is_hram,
  output logic        is_dma_reg,
  output logic        is_other
);

  assign is_hram    = (cpu_addr >= HRAM_LO) &&
                      (cpu_addr <= HRAM_HI);
  assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign is_other   = ~(is_hram | is_dma_reg);

endmodule

// File: rtl/oam_dma_arbiter.sv
// External bus arbiter between the CPU and the OAM DMA engine.
// DMA copies 160 bytes from {src,8'h00} into OAM, one per cycle.
module oam_dma_arbiter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic        hram_wr,
  output logic [7:0]  hram_wdata,
  input  logic [7:0]  hram_rdata,
  output logic        oam_wr,
  output logic [7:0]  oam_idx,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  dma_state_t state_q;
  dma_state_t state_d;
  reg8_t      src_q;
  reg8_t      idx_q;
  reg8_t      oam_idx_q;
  reg8_t      oam_data_q;
  logic       restart_q;
  logic       oam_pend_q;
  logic       is_hram;
  logic       is_dma_reg;
  logic       is_other;
  logic       cpu_re;
  logic       dma_wr;
  logic       dma_rd;

  bus_region_decoder u_dec (
    .cpu_addr   (cpu_addr),
    .is_hram    (is_hram),
    .is_dma_reg (is_dma_reg),
    .is_other   (is_other)
  );

  // A simultaneous write suppresses the read
  assign cpu_re = cpu_rd & ~cpu_wr;
  assign dma_wr = cpu_wr & is_dma_reg;
  assign dma_rd = (state_q == DMA_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMA_IDLE: begin
        if (dma_wr) state_d = DMA_START;
      end
      DMA_START: begin
        if (!dma_wr) state_d = DMA_ACTIVE;
      end
      DMA_ACTIVE: begin
        if (dma_wr)
          state_d = DMA_START;
        else if (idx_q == DMA_LAST)
          state_d = DMA_DRAIN;
      end
      DMA_DRAIN: begin
        state_d = dma_wr ? DMA_START : DMA_IDLE;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      idx_q      <= '0;
      restart_q  <= 1'b0;
      oam_pend_q <= 1'b0;
      oam_idx_q  <= '0;
      oam_data_q <= '0;
    end else begin
      if (dma_wr) begin
        src_q <= cpu_wdata;
        idx_q <= '0;
      end else if (dma_rd) begin
        idx_q <= idx_q + 8'd1;
      end
      if (state_d == DMA_IDLE)
        restart_q <= 1'b0;
      else if (dma_wr && (state_q == DMA_ACTIVE ||
                          state_q == DMA_DRAIN))
        restart_q <= 1'b1;
      oam_pend_q <= dma_rd;
      if (dma_rd) begin
        oam_idx_q  <= idx_q;
        oam_data_q <= mem_rdata;
      end
    end
  end

  assign dma_active = (state_q == DMA_ACTIVE) ||
                      (state_q == DMA_DRAIN)  ||
                      (state_q == DMA_START && restart_q);

  assign oam_wr    = oam_pend_q;
  assign oam_idx   = oam_idx_q;
  assign oam_wdata = oam_data_q;

  always_comb begin
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    hram_addr  = '0;
    hram_wr    = 1'b0;
    hram_wdata = '0;
    cpu_rdata  = 8'hFF;
    if (dma_rd) begin
      mem_rd   = 1'b1;
      mem_addr = {src_eff(src_q), idx_q};
    end else if (is_other && !dma_active &&
                 (cpu_re || cpu_wr)) begin
      mem_addr = cpu_addr;
      mem_rd   = cpu_re;
      mem_wr   = cpu_wr;
      if (cpu_wr) mem_wdata = cpu_wdata;
    end
    if (is_hram) begin
      hram_addr = cpu_addr[6:0] - HRAM_LO[6:0];
      hram_wr   = cpu_wr;
      if (cpu_wr) hram_wdata = cpu_wdata;
    end
    if (cpu_re) begin
      unique case (1'b1)
        is_hram:    cpu_rdata = hram_rdata;
        is_dma_reg: cpu_rdata = src_q;
        is_other:   cpu_rdata = dma_active ? 8'hFF
                                           : mem_rdata;
        default:    cpu_rdata = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: routing table plus
// full-transfer, restart and mid-transfer reset sequences.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic        hram_wr;
  logic [7:0]  hram_wdata;
  logic [7:0]  hram_rdata;
  logic        oam_wr;
  logic [7:0]  oam_idx;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int checks = 0;
  int fails  = 0;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hram_addr  (hram_addr),
    .hram_wr    (hram_wr),
    .hram_wdata (hram_wdata),
    .hram_rdata (hram_rdata),
    .oam_wr     (oam_wr),
    .oam_idx    (oam_idx),
    .oam_wdata  (oam_wdata),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  mrd;
    logic [7:0]  hrd;
    logic        e_mrd;
    logic        e_mwr;
    logic [15:0] e_maddr;
    logic [7:0]  e_mwd;
    logic        e_hwr;
    logic [6:0]  e_haddr;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t iv[10];
  vec_t dv[5];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] f(input logic [7:0] s,
                                   input int k);
    return 8'(k) ^ s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cpu_addr  = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = '0;
  endtask

  task automatic apply(input vec_t v);
    cpu_addr   = v.addr;
    cpu_rd     = v.rd;
    cpu_wr     = v.wr;
    cpu_wdata  = v.wd;
    mem_rdata  = v.mrd;
    hram_rdata = v.hrd;
  endtask

  task automatic start_dma(input logic [7:0] v,
                           input logic twice);
    cpu_addr  = 16'hFF46;
    cpu_wr    = 1'b1;
    cpu_wdata = v;
    #1;
    chk("start_wr", {mem_wr, mem_rd, dma_active, hram_wr}, 64'h0);
    step();
    clr();
    #1;
    chk("start_st", {mem_rd, dma_active}, 64'h0);
    if (twice) begin
      cpu_addr  = 16'hFF46;
      cpu_wr    = 1'b1;
      cpu_wdata = v;
      step();
      clr();
      #1;
      chk("start_hold", {mem_rd, dma_active}, 64'h0);
    end
  endtask

  // Runs ACTIVE cycles k=0..stop; returns inside cycle 'stop'
  task automatic xfer(input logic [7:0] s,
                      input logic [7:0] hi,
                      input int stop,
                      input logic inj);
    for (int k = 0; k <= stop; k++) begin
      step();
      clr();
      mem_rdata = f(s, k);
      if (inj && k >= 10 && k <= 14) begin
        apply(dv[k-10]);
        mem_rdata = f(s, k);
      end
      #1;
      if (k == 0)
        chk("dma_k0",
            {mem_rd, mem_wr, mem_addr, dma_active, oam_wr},
            {1'b1, 1'b0, hi, 8'(k), 1'b1, 1'b0});
      else
        chk("dma_k",
            {mem_rd, mem_wr, mem_addr, dma_active, oam_wr,
             oam_idx, oam_wdata},
            {1'b1, 1'b0, hi, 8'(k), 1'b1, 1'b1,
             8'(k - 1), f(s, k - 1)});
      if (inj && k >= 10 && k <= 14)
        chk("dma_cpu",
            {mem_wr, hram_wr, hram_addr, cpu_rdata},
            {dv[k-10].e_mwr, dv[k-10].e_hwr,
             dv[k-10].e_haddr, dv[k-10].e_rdata});
    end
  endtask

  task automatic drain(input logic [7:0] s);
    step();
    clr();
    #1;
    chk("drain",
        {mem_rd, dma_active, oam_wr, oam_idx, oam_wdata},
        {1'b0, 1'b1, 1'b1, 8'd159, f(s, 159)});
    step();
    #1;
    chk("post_idle", {mem_rd, dma_active, oam_wr}, 64'h0);
  endtask

  initial begin
    //        addr      rd   wr   wd     mrd    hrd    mrd? mwr? maddr     mwd    hwr  haddr  rdata
    iv[0] = '{16'h8000,1'b0,1'b1,8'h33,8'h00,8'h00,1'b0,1'b1,16'h8000,8'h33,1'b0,7'h00,8'hFF};
    iv[1] = '{16'h8000,1'b1,1'b0,8'h00,8'hA7,8'h00,1'b1,1'b0,16'h8000,8'h00,1'b0,7'h00,8'hA7};
    iv[2] = '{16'h8000,1'b1,1'b1,8'h44,8'hA7,8'h00,1'b0,1'b1,16'h8000,8'h44,1'b0,7'h00,8'hFF};
    iv[3] = '{16'hFF90,1'b1,1'b0,8'h00,8'h00,8'h5A,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h10,8'h5A};
    iv[4] = '{16'hFF90,1'b0,1'b1,8'h5A,8'h00,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b1,7'h10,8'hFF};
    iv[5] = '{16'hFF80,1'b1,1'b0,8'h00,8'h00,8'h11,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h00,8'h11};
    iv[6] = '{16'hFFFE,1'b1,1'b0,8'h00,8'h00,8'h22,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h7E,8'h22};
    iv[7] = '{16'hFFFF,1'b1,1'b0,8'h00,8'h3C,8'h00,1'b1,1'b0,16'hFFFF,8'h00,1'b0,7'h00,8'h3C};
    iv[8] = '{16'hFF7F,1'b1,1'b0,8'h00,8'h4D,8'h00,1'b1,1'b0,16'hFF7F,8'h00,1'b0,7'h00,8'h4D};
    iv[9] = '{16'hFF46,1'b1,1'b0,8'h00,8'h99,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h00,8'h00};
    // during DMA with src C1 (only cpu-side fields checked)
    dv[0] = '{16'hC000,1'b1,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h00,8'hFF};
    dv[1] = '{16'hFF90,1'b0,1'b1,8'h5A,8'h00,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b1,7'h10,8'hFF};
    dv[2] = '{16'hFF90,1'b1,1'b0,8'h00,8'h00,8'h5A,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h10,8'h5A};
    dv[3] = '{16'hC000,1'b0,1'b1,8'h33,8'h00,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h00,8'hFF};
    dv[4] = '{16'hFF46,1'b1,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,16'h0000,8'h00,1'b0,7'h00,8'hC1};

    rst_n      = 1'b0;
    mem_rdata  = '0;
    hram_rdata = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset",
        {mem_rd, mem_wr, hram_wr, oam_wr, dma_active,
         mem_addr, oam_idx, oam_wdata, cpu_rdata},
        {5'b0, 16'h0, 8'h0, 8'h0, 8'hFF});
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      apply(iv[i]);
      #1;
      chk($sformatf("idle_vec%0d", i),
          {mem_rd, mem_wr, mem_addr, mem_wdata,
           hram_wr, hram_addr, cpu_rdata},
          {iv[i].e_mrd, iv[i].e_mwr, iv[i].e_maddr, iv[i].e_mwd,
           iv[i].e_hwr, iv[i].e_haddr, iv[i].e_rdata});
      if (iv[i].e_hwr)
        chk("hram_wd", hram_wdata, iv[i].wd);
      chk("idle_act", dma_active, 64'h0);
    end

    step();
    clr();
    start_dma(8'hC1, 1'b0);
    xfer(8'hC1, 8'hC1, 159, 1'b1);
    drain(8'hC1);

    step();
    start_dma(8'hFE, 1'b1);
    xfer(8'hFE, 8'hDE, 159, 1'b0);
    drain(8'hFE);
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    #1;
    chk("rd_src_fe", cpu_rdata, 64'hFE);

    step();
    clr();
    start_dma(8'hC1, 1'b0);
    xfer(8'hC1, 8'hC1, 50, 1'b0);
    cpu_addr  = 16'hFF46;
    cpu_wr    = 1'b1;
    cpu_wdata = 8'hC2;
    #1;
    chk("rs_wr", {mem_rd, mem_wr, mem_addr},
        {1'b1, 1'b0, 16'hC132});
    step();
    clr();
    #1;
    chk("rs_start",
        {mem_rd, dma_active, oam_wr, oam_idx, oam_wdata},
        {1'b0, 1'b1, 1'b1, 8'd50, f(8'hC1, 50)});
    xfer(8'hC2, 8'hC2, 159, 1'b0);
    drain(8'hC2);

    step();
    start_dma(8'hC3, 1'b0);
    xfer(8'hC3, 8'hC3, 80, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid",
        {mem_rd, mem_wr, oam_wr, dma_active,
         mem_addr, oam_idx, oam_wdata, cpu_rdata},
        {4'b0, 16'h0, 8'h0, 8'h0, 8'hFF});
    step();
    chk("rst_hold", {mem_rd, oam_wr, dma_active}, 64'h0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_after", {mem_rd, oam_wr, dma_active}, 64'h0);
    end
    start_dma(8'hC1, 1'b0);
    xfer(8'hC1, 8'hC1, 159, 1'b0);
    drain(8'hC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
